sap_cpu_core: RTL
=================

# sap_cpu_core

Parametrised, self-contained successor to the 8-bit tri-state-bus CPU. It uses a single synchronous clock and replaces the tri-state bus with internal muxing. It adds:
- flag-driven conditional jumps;
- a valid/ready input port and a pulsed output port;
- a halt/start run control;
- a program-load port into the internal register-file RAM.

It sits directly under the Tiny Tapeout top wrapper, which maps its ports onto ui/uo/uio pins.

## Interface
Parameters:
- DATA_W, 8, datapath and memory word width; must be ≥ ADDR_W+4.
- ADDR_W, 4, address width; memory depth and PC range are 2^ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  leave HALT and begin fetching at the current PC.
- prog_we  input  1  program write strobe; honoured only while halted=1.
- prog_addr  input  ADDR_W  program write address.
- prog_data  input  DATA_W  program write data.
- in_data  input  DATA_W  input port data.
- in_valid  input  1  input data valid.
- in_ready  output  1  core is accepting input (IN instruction, EXEC1).
- out_data  output  DATA_W  output register.
- out_valid  output  1  one-cycle pulse when out_data is updated.
- halted  output  1  core is in HALT.
- cf  output  1  carry flag.
- zf  output  1  zero flag.
- pc  output  ADDR_W  program counter (debug).

## Operation
- Instruction word layout:
  - opcode = ir[DATA_W-1:DATA_W-4];
  - operand = ir[ADDR_W-1:0];
  - the immediate for LDI is the operand, zero-extended to DATA_W.
- Memory: 2^ADDR_W × DATA_W flops with combinational read at MAR. Reset does not clear it.
- States: HALT, FETCH, DECODE, EXEC1, EXEC2.
- State actions:
  - FETCH: MAR ← PC.
  - DECODE: IR ← mem[MAR]; PC ← PC+1, wrapping from 2^ADDR_W−1 to 0.
- Opcodes (action in EXEC1 / EXEC2):
  - 0 NOP: — / —.
  - 1 LDA: MAR ← op / A ← mem.
  - 2 ADD: MAR ← op / B ← mem, A ← A+mem, flags.
  - 3 SUB: MAR ← op / B ← mem, A ← A+~mem+1, flags.
  - 4 STA: MAR ← op / mem ← A.
  - 5 LDI: A ← imm.
  - 6 JMP: PC ← op.
  - 7 JC: PC ← op if cf.
  - 8 JZ: PC ← op if zf.
  - 9 IN: wait for in_valid, then A ← in_data.
  - E OUT: out_data ← A, out_valid ← 1.
  - F HLT: go to HALT.
  - A–D: NOP.
- Flags:
  - Only ADD and SUB update the flags.
  - cf = carry out of bit DATA_W−1. For SUB, cf=1 means no borrow (A ≥ mem).
  - zf = (DATA_W-bit result == 0).
  - Arithmetic is modulo 2^DATA_W.
- State transitions:
  - Opcodes 1–4 go EXEC1 → EXEC2 → FETCH.
  - All other opcodes go EXEC1 → FETCH, except IN and HLT.
  - IN stays in EXEC1 with in_ready=1 until in_valid=1. The transfer happens on that edge, then the core goes to FETCH.
  - HLT goes to HALT. HALT exits to FETCH only on start=1; PC is retained.
- Program load:
  - prog_we while halted=1 writes mem[prog_addr] on the edge.
  - prog_we while running is ignored.
  - prog_we and start in the same cycle: the write occurs and the core goes to FETCH. The written word is visible to that fetch.

## Timing
- Reset values: state=HALT, halted=1, pc=0, A=B=MAR=IR=0, out_data=0, out_valid=0, in_ready=0, cf=0, zf=0.
- rst asserted in any state, including mid-instruction or during an IN wait, wins over all other inputs on that edge.
- Instruction latency from FETCH to the next FETCH:
  - 3 cycles: NOP, LDI, JMP, JC, JZ, OUT.
  - 4 cycles: LDA, ADD, SUB, STA.
  - IN: 3 cycles plus the number of wait cycles.
- out_valid is high for exactly the one cycle after the OUT EXEC1 edge.
- in_ready is combinational from state and IR. It falls in the cycle after the accepting edge.
- halted goes high in the cycle after the HLT EXEC1 edge.

## Configuration
- SAP_CPU_COND_JUMP_EN defined: JC and JZ behave as specified.
- SAP_CPU_COND_JUMP_EN undefined: opcodes 7 and 8 execute as NOP (3 cycles, PC not loaded). Flags are still computed and output.

## Test plan
- Program load and basic run:
  - Stimulus: while halted, load mem[0..3] = 1E, 2F, E0, F0 and mem[14]=05, mem[15]=03; pulse start.
  - Response: out_data=08 with a single out_valid pulse; halted=1; cf=0; zf=0; total 14 cycles from start to halted.
- Subtract to zero and JZ:
  - Stimulus: program 57, 3F, 8A (mem[15]=07); mem[10]=E0.
  - Response: A=00, zf=1, cf=1; PC jumps to 0A; out_data=00.
- Carry and JC, run once per build:
  - Stimulus: A=FF via LDA; ADD a word holding 01; then JC 0C.
  - Response: A=00, cf=1, zf=1.
  - With the macro defined, PC=0C after the jump. Without it, PC falls through to the next address.
- IN handshake:
  - Stimulus: execute IN; hold in_valid=0 for 5 cycles, then drive in_valid=1 with in_data=3C.
  - Response: in_ready=1 and PC frozen during the wait; A=3C; in_ready=0 the next cycle.
- Reset mid-instruction and ignored writes:
  - Stimulus: assert rst during ADD EXEC2.
  - Response: all outputs at their reset values after the edge; memory contents unchanged.
  - Stimulus: prog_we while running.
  - Response: no write occurs.
- PC wrap:
  - Stimulus: NOP at address 15 with mem[0]=F0.
  - Response: pc reads 0 after the DECODE of address 15; the core halts.

Source files
------------

// File: rtl/sap_cpu_core.sv
// sap_cpu_core: multi-cycle 8-bit accumulator CPU with internal muxing
// instead of a tri-state bus. It has a flop register-file RAM, flag-driven
// conditional jumps, a valid/ready input port, a pulsed output port, halt/start
// run control and a program-load port that is active while halted.
//
// Optional feature macro: SAP_CPU_COND_JUMP_EN
//   defined   : JC/JZ load PC from the operand when cf/zf is set.
//   undefined : opcodes 7/8 execute as NOP. Flags are still computed.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 leave HALT and fetch at the current PC
//   prog_we/addr/data     program write into memory, honoured only while halted
//   in_data, in_valid     input port (consumed by IN)
//   in_ready              combinational: IN instruction waiting in EXEC1
//   out_data, out_valid   output register and its one-cycle update pulse
//   halted                core is in HALT
//   cf, zf                carry / zero flags
//   pc                    program counter (debug)
module sap_cpu_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              cf,
  output logic              zf,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned SUM_W = DATA_W + 1;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_IN  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_EXEC1,
    S_EXEC2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic              r_cf;
  logic              r_zf;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] w_alu_b;
  logic [SUM_W-1:0]  w_sum;
  logic              w_is_sub;
  logic              w_jc_take;
  logic              w_jz_take;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_opcode  = r_ir[DATA_W-1 -: 4];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_imm     = DATA_W'(w_operand);
  assign w_mem_rd  = r_mem[r_mar];

  // Shared adder: SUB is A + ~mem + 1, so carry out means "no borrow".
  assign w_is_sub = (w_opcode == OP_SUB);
  assign w_alu_b  = w_is_sub ? ~w_mem_rd : w_mem_rd;
  assign w_sum    = SUM_W'(r_a) + SUM_W'(w_alu_b) + SUM_W'(w_is_sub);

`ifdef SAP_CPU_COND_JUMP_EN
  assign w_jc_take = r_cf;
  assign w_jz_take = r_zf;
`else
  assign w_jc_take = 1'b0;
  assign w_jz_take = 1'b0;
`endif

  // Single write port: program load while halted, STA in EXEC2; reset blocks both.
  assign w_mem_we    = !rst && (((r_state == S_HALT) && prog_we) ||
                                ((r_state == S_EXEC2) && (w_opcode == OP_STA)));
  assign w_mem_waddr = (r_state == S_HALT) ? prog_addr : r_mar;
  assign w_mem_wdata = (r_state == S_HALT) ? prog_data : r_a;

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Control FSM and datapath registers. The B latch of the bus-based original
  // is not kept: the ALU takes its operand straight from memory and B has no reader.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HALT;
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_cf        <= 1'b0;
      r_zf        <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_HALT: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_mar   <= r_pc;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir    <= w_mem_rd;
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= S_EXEC1;
        end
        S_EXEC1: begin
          r_state <= S_FETCH;
          case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              r_mar   <= w_operand;
              r_state <= S_EXEC2;
            end
            OP_LDI: r_a <= w_imm;
            OP_JMP: r_pc <= w_operand;
            OP_JC:  if (w_jc_take) r_pc <= w_operand;
            OP_JZ:  if (w_jz_take) r_pc <= w_operand;
            OP_IN: begin
              if (in_valid) r_a <= in_data;
              else          r_state <= S_EXEC1;
            end
            OP_OUT: begin
              r_out       <= r_a;
              r_out_valid <= 1'b1;
            end
            OP_HLT: r_state <= S_HALT;
            default: ;
          endcase
        end
        S_EXEC2: begin
          r_state <= S_FETCH;
          case (w_opcode)
            OP_LDA: r_a <= w_mem_rd;
            OP_ADD, OP_SUB: begin
              r_a  <= w_sum[DATA_W-1:0];
              r_cf <= w_sum[DATA_W];
              r_zf <= (w_sum[DATA_W-1:0] == '0);
            end
            default: ;
          endcase
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign in_ready  = (r_state == S_EXEC1) && (w_opcode == OP_IN);
  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign halted    = (r_state == S_HALT);
  assign cf        = r_cf;
  assign zf        = r_zf;
  assign pc        = r_pc;

endmodule
